// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, R/W bit
// meaning and the default glitch-filter length.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  localparam int I2C_FILT_LEN_DEFAULT = 3;

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions one asynchronous I2C line: 2-flop synchronizer followed by a
// glitch filter that only changes its level after FILT_LEN consecutive
// samples disagree with it. Rise/fall pulses are registered together with
// the level, so an input edge shows up 2+FILT_LEN clk later.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset (line presets to 1 = bus idle)
//   line_i  raw bus line
//   level_o filtered level
//   rise_o  one-cycle pulse when level_o goes 0->1
//   fall_o  one-cycle pulse when level_o goes 1->0
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int FILT_LEN = I2C_FILT_LEN_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    sync1_d = line_i;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // cnt_q counts samples that already disagree; the FILT_LEN-th one flips
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target exposing a register bank through single-cycle strobes.
// Protocol: START, address byte (7-bit + R/W), register pointer byte,
// then write data bytes, or (after a repeated START with R/W=1) read bytes.
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   i2c_sclk   bus SCL (never stretched)
//   i2c_sdat   bus SDA, open drain (drives 0 or releases)
//   reg_addr   current register pointer
//   wr_data    byte received for a write
//   wr_en      one-cycle write strobe (wr_data -> reg_addr)
//   rd_req     one-cycle read request for reg_addr
//   rd_data    bank read data, sampled 2 clk after rd_req
//   busy       high from an address-matched START until STOP
//   nack_seen  one-cycle pulse when the master NACKs a read byte
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h48,
  parameter int         FILT_LEN   = I2C_FILT_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_sclk,
  inout  wire        i2c_sdat,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_en,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       nack_seen
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .rst_n(reset), .line_i(i2c_sclk),
    .level_o(scl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .rst_n(reset), .line_i(i2c_sdat),
    .level_o(sda), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       in_slot_q, in_slot_d;     // ACK bit slot has begun (after its SCL fall)
  logic       rw_q, rw_d;
  logic       first_q, first_d;         // write address is the pointer-setting one
  logic       addr_seen_q, addr_seen_d; // an address matched since the last STOP
  logic       wr_en_q, wr_en_d;
  logic       rd_req_q, rd_req_d;
  logic       load_q, load_d;           // delays tx load to 2 clk after rd_req
  logic       nack_seen_q, nack_seen_d;

  logic [7:0] rx_byte;
  logic       start_det, stop_det;

  assign rx_byte   = {rx_q[6:0], sda};
  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    reg_addr_d  = reg_addr_q;
    wr_data_d   = wr_data_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    in_slot_d   = in_slot_q;
    rw_d        = rw_q;
    first_d     = first_q;
    addr_seen_d = addr_seen_q;
    wr_en_d     = 1'b0;
    rd_req_d    = 1'b0;
    nack_seen_d = 1'b0;
    load_d      = rd_req_q;

    // Bus conditions take priority over any SCL edge in the same cycle.
    if (stop_det) begin
      state_d     = ST_IDLE;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      addr_seen_d = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      in_slot_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_REG, ST_WDATA: begin
          if (scl_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            in_slot_d = 1'b0;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ST_ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_d     = ST_ADDR_ACK;
                  busy_d      = 1'b1;
                  rw_d        = rx_byte[0];
                  first_d     = ~addr_seen_q;
                  addr_seen_d = 1'b1;
                end else begin
                  state_d = ST_IGNORE;
                end
              end else if (state_q == ST_REG) begin
                reg_addr_d = rx_byte;
                state_d    = ST_REG_ACK;
              end else begin
                wr_data_d = rx_byte;
                wr_en_d   = 1'b1;
                state_d   = ST_WDATA_ACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (scl_fall && !in_slot_q) begin
            in_slot_d = 1'b1;
            sda_oe_d  = 1'b1;
          end else if (scl_rise && in_slot_q) begin
            if (state_q == ST_ADDR_ACK && rw_q == I2C_RW_READ) rd_req_d = 1'b1;
          end else if (scl_fall && in_slot_q) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            if (state_q == ST_ADDR_ACK && rw_q == I2C_RW_READ) begin
              state_d  = ST_RDATA;
              sda_oe_d = ~tx_q[7];
              tx_d     = {tx_q[6:0], 1'b0};
            end else if (state_q == ST_ADDR_ACK) begin
              state_d = first_q ? ST_REG : ST_WDATA;
            end else if (state_q == ST_REG_ACK) begin
              state_d = ST_WDATA;
            end else begin
              reg_addr_d = reg_addr_q + 8'd1;
              state_d    = ST_WDATA;
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d   = ST_RDATA_ACK;
              in_slot_d = 1'b0;
            end
          end else if (scl_fall) begin
            // a 1 bit is released, a 0 bit is driven
            sda_oe_d = ~tx_q[7];
            tx_d     = {tx_q[6:0], 1'b0};
          end
        end
        ST_RDATA_ACK: begin
          if (scl_fall && !in_slot_q) begin
            in_slot_d = 1'b1;
            sda_oe_d  = 1'b0;
          end else if (scl_rise && in_slot_q) begin
            if (!sda) begin
              reg_addr_d = reg_addr_q + 8'd1;
              rd_req_d   = 1'b1;
            end else begin
              nack_seen_d = 1'b1;
              state_d     = ST_IGNORE;
            end
          end else if (scl_fall && in_slot_q) begin
            state_d   = ST_RDATA;
            bit_cnt_d = '0;
            sda_oe_d  = ~tx_q[7];
            tx_d      = {tx_q[6:0], 1'b0};
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end

    if (load_q) tx_d = rd_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      reg_addr_q  <= '0;
      wr_data_q   <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      in_slot_q   <= 1'b0;
      rw_q        <= I2C_RW_WRITE;
      first_q     <= 1'b0;
      addr_seen_q <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_req_q    <= 1'b0;
      load_q      <= 1'b0;
      nack_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      reg_addr_q  <= reg_addr_d;
      wr_data_q   <= wr_data_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      in_slot_q   <= in_slot_d;
      rw_q        <= rw_d;
      first_q     <= first_d;
      addr_seen_q <= addr_seen_d;
      wr_en_q     <= wr_en_d;
      rd_req_q    <= rd_req_d;
      load_q      <= load_d;
      nack_seen_q <= nack_seen_d;
    end
  end

  assign i2c_sdat  = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_addr  = reg_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_en     = wr_en_q;
  assign rd_req    = rd_req_q;
  assign busy      = busy_q;
  assign nack_seen = nack_seen_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged I2C master drives the bus, a bank model
// answers rd_req, and a monitor pops expected strobes from queues.
module tb_i2c_slave;

  localparam int Q = 8;   // clk from SCL edge to SDA change / next SCL edge
  localparam int H = 16;  // SCL high time in clk

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m;
  logic       sda_low;
  wire        i2c_sdat;
  logic [7:0] reg_addr, wr_data;
  logic [7:0] rd_data = 8'h00;
  logic       wr_en, rd_req, busy, nack_seen;

  logic [7:0]  mem [256];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic        exp_nack [$];
  logic        watch;
  int          drive_viol, busy_viol;

  always #5 clk = ~clk;

  assign i2c_sdat = sda_low ? 1'b0 : 1'bz;
  pullup (i2c_sdat);

  i2c_slave #(.SLAVE_ADDR(7'h48), .FILT_LEN(3)) dut (
    .clk(clk), .reset(reset), .i2c_sclk(scl_m), .i2c_sdat(i2c_sdat),
    .reg_addr(reg_addr), .wr_data(wr_data), .wr_en(wr_en), .rd_req(rd_req),
    .rd_data(rd_data), .busy(busy), .nack_seen(nack_seen)
  );

  // Bank model: registered read, data ready for the DUT 2 clk after rd_req.
  always @(posedge clk) begin
    if (rd_req) rd_data <= mem[reg_addr];
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(input string name, input logic [15:0] act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected strobe with 0x%0h, required none", name, act);
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      if (wr_en) begin
        if (exp_wr.size() == 0) unexpected("wr_en", {reg_addr, wr_data});
        else chk("wr_en addr/data", {16'h0, reg_addr, wr_data}, {16'h0, exp_wr.pop_front()});
      end
      if (rd_req) begin
        if (exp_rd.size() == 0) unexpected("rd_req", {8'h0, reg_addr});
        else chk("rd_req addr", {24'h0, reg_addr}, {24'h0, exp_rd.pop_front()});
      end
      if (nack_seen) begin
        if (exp_nack.size() == 0) unexpected("nack_seen", 16'h1);
        else chk("nack_seen", 32'(nack_seen), 32'(exp_nack.pop_front()));
      end
      if (watch && !sda_low && i2c_sdat === 1'b0) drive_viol++;
      if (watch && busy) busy_viol++;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_low = 1'b0; clks(Q);
    scl_m = 1'b1;   clks(H);
    sda_low = 1'b1; clks(H);
    scl_m = 1'b0;   clks(Q);
  endtask

  task automatic bus_stop();
    sda_low = 1'b1; clks(Q);
    scl_m = 1'b1;   clks(H);
    sda_low = 1'b0; clks(H);
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    sda_low = ~b;
    if (glitch) begin
      clks(3); scl_m = 1'b1; clks(1); scl_m = 1'b0; clks(Q - 4);
    end else begin
      clks(Q);
    end
    scl_m = 1'b1;
    if (glitch) begin
      clks(H / 2); sda_low = ~sda_low; clks(1); sda_low = ~sda_low; clks(H / 2 - 1);
    end else begin
      clks(H);
    end
    scl_m = 1'b0;
    clks(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_low = 1'b0; clks(Q);
    scl_m = 1'b1;   clks(H / 2);
    b = (i2c_sdat === 1'b0) ? 1'b0 : 1'b1;
    clks(H / 2);
    scl_m = 1'b0;   clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic glitch, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i], glitch);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack, 1'b0);
  endtask

  logic       ack;
  logic [7:0] rd;

  initial begin
    reset = 1'b0; scl_m = 1'b1; sda_low = 1'b0; watch = 1'b0;
    drive_viol = 0; busy_viol = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h10] = 8'h3C; mem[8'hFF] = 8'hC3; mem[8'h00] = 8'h81; mem[8'h30] = 8'h00;

    clks(3);
    chk("reset sda released", 32'(i2c_sdat), 32'h1);
    chk("reset reg_addr", 32'(reg_addr), 32'h0);
    chk("reset wr_data", 32'(wr_data), 32'h0);
    chk("reset strobes/busy", {28'h0, wr_en, rd_req, busy, nack_seen}, 32'h0);
    reset = 1'b1;
    clks(10);

    // Write 0xA5 to register 0x10
    bus_start();
    write_byte(8'h90, 1'b0, ack); chk("wr addr ack", 32'(ack), 32'h0);
    write_byte(8'h10, 1'b0, ack); chk("wr reg ack", 32'(ack), 32'h0);
    exp_wr.push_back({8'h10, 8'hA5});
    write_byte(8'hA5, 1'b0, ack); chk("wr data ack", 32'(ack), 32'h0);
    chk("wr busy before stop", 32'(busy), 32'h1);
    chk("wr reg_addr incremented", 32'(reg_addr), 32'h11);
    bus_stop();
    chk("wr busy after stop", 32'(busy), 32'h0);

    // Read register 0x10 via repeated START, master NACK
    bus_start();
    write_byte(8'h90, 1'b0, ack); chk("rd addr ack", 32'(ack), 32'h0);
    write_byte(8'h10, 1'b0, ack); chk("rd reg ack", 32'(ack), 32'h0);
    bus_start();
    exp_rd.push_back(8'h10);
    write_byte(8'h91, 1'b0, ack); chk("rd addr2 ack", 32'(ack), 32'h0);
    exp_nack.push_back(1'b1);
    read_byte(rd, 1'b1);          chk("rd byte", 32'(rd), 32'h3C);
    bus_stop();
    chk("rd busy after stop", 32'(busy), 32'h0);

    // Burst read from 0xFF, wraps to 0x00
    bus_start();
    write_byte(8'h90, 1'b0, ack); chk("burst addr ack", 32'(ack), 32'h0);
    write_byte(8'hFF, 1'b0, ack); chk("burst reg ack", 32'(ack), 32'h0);
    bus_start();
    exp_rd.push_back(8'hFF);
    write_byte(8'h91, 1'b0, ack); chk("burst addr2 ack", 32'(ack), 32'h0);
    exp_rd.push_back(8'h00);
    read_byte(rd, 1'b0);          chk("burst byte0", 32'(rd), 32'hC3);
    exp_nack.push_back(1'b1);
    read_byte(rd, 1'b1);          chk("burst byte1", 32'(rd), 32'h81);
    bus_stop();

    // Wrong address is ignored, then a repeated START to the right one
    bus_start();
    watch = 1'b1;
    write_byte(8'h92, 1'b0, ack); chk("bad addr nack", 32'(ack), 32'h1);
    write_byte(8'h55, 1'b0, ack); chk("bad addr data nack", 32'(ack), 32'h1);
    watch = 1'b0;
    chk("bad addr sda never low", 32'(drive_viol), 32'h0);
    chk("bad addr busy stays 0", 32'(busy_viol), 32'h0);
    bus_start();
    write_byte(8'h90, 1'b0, ack); chk("good addr after bad ack", 32'(ack), 32'h0);
    write_byte(8'h40, 1'b0, ack); chk("good reg after bad ack", 32'(ack), 32'h0);
    exp_wr.push_back({8'h40, 8'h66});
    write_byte(8'h66, 1'b0, ack); chk("good data after bad ack", 32'(ack), 32'h0);
    bus_stop();

    // Single-clk glitches on SCL (low phase) and SDA (high phase)
    bus_start();
    write_byte(8'h90, 1'b0, ack); chk("glitch addr ack", 32'(ack), 32'h0);
    write_byte(8'h20, 1'b0, ack); chk("glitch reg ack", 32'(ack), 32'h0);
    exp_wr.push_back({8'h20, 8'h5A});
    write_byte(8'h5A, 1'b1, ack); chk("glitch data ack", 32'(ack), 32'h0);
    chk("glitch busy held", 32'(busy), 32'h1);
    bus_stop();
    chk("glitch wr_data", 32'(wr_data), 32'h5A);

    // Reset while the target drives a 0 data bit
    bus_start();
    write_byte(8'h90, 1'b0, ack);
    write_byte(8'h30, 1'b0, ack);
    bus_start();
    exp_rd.push_back(8'h30);
    write_byte(8'h91, 1'b0, ack); chk("rst addr ack", 32'(ack), 32'h0);
    sda_low = 1'b0; clks(Q); scl_m = 1'b1; clks(4);
    chk("rst sda driven before", 32'(i2c_sdat), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst sda released async", 32'(i2c_sdat), 32'h1);
    chk("rst reg_addr", 32'(reg_addr), 32'h0);
    chk("rst wr_data", 32'(wr_data), 32'h0);
    chk("rst strobes/busy", {28'h0, wr_en, rd_req, busy, nack_seen}, 32'h0);
    clks(5);
    reset = 1'b1;
    clks(20);

    // Target works again after reset
    bus_start();
    write_byte(8'h90, 1'b0, ack); chk("post-rst addr ack", 32'(ack), 32'h0);
    write_byte(8'h07, 1'b0, ack); chk("post-rst reg ack", 32'(ack), 32'h0);
    bus_stop();
    chk("post-rst reg_addr", 32'(reg_addr), 32'h07);

    clks(20);
    chk("wr queue drained", 32'(exp_wr.size()), 32'h0);
    chk("rd queue drained", 32'(exp_rd.size()), 32'h0);
    chk("nack queue drained", 32'(exp_nack.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (responder) for the on-chip I2C master; the FPGA-side register bank appears as a slave device for bench loopback and for external-master access.
- Oversamples SCL/SDA on the system clock, detects START/repeated-START/STOP, matches a 7-bit address, accepts a register pointer, then writes data bytes or returns read data.
- Exposes a simple single-cycle register-bank strobe interface.

Parameters:
- SLAVE_ADDR, 7'h48, 7-bit address this target ACKs.
- FILT_LEN, 3, number of consecutive equal samples needed before a filtered SCL/SDA level changes.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- i2c_sclk  input  1  bus SCL (target never stretches).
- i2c_sdat  inout  1  bus SDA, open drain: drives 0 or releases to 'z'.
- reg_addr  output  8  current register pointer.
- wr_data  output  8  byte received for a write.
- wr_en  output  1  one-cycle pulse; write wr_data to reg_addr.
- rd_req  output  1  one-cycle pulse; bank must present reg_addr contents.
- rd_data  input  8  read data, valid 2 clk after rd_req.
- busy  output  1  high from an address-matched START until STOP.
- nack_seen  output  1  one-cycle pulse when the master NACKs a read byte.

Behaviour:
- Reset values while reset=0: SDA released, reg_addr=0, wr_data=0, wr_en=0, rd_req=0, busy=0, nack_seen=0, state IDLE, filters preset to 1.
- Input path: 2-flop synchronizer, then a FILT_LEN glitch filter per line. Edges are detected on the filtered levels; edge-detect latency is 2+FILT_LEN clk.
- START: filtered SDA falls while SCL=1. Accepted from any state, including mid-byte; it clears the bit counter and enters ADDR.
- STOP: filtered SDA rises while SCL=1. Accepted from any state; goes to IDLE, releases SDA, clears busy.
- Bit timing: SDA is sampled on the filtered SCL rising edge. The target changes SDA only on the first clk after a filtered SCL falling edge and holds it through the whole high phase.
- Shift order is MSB first; a 3-bit counter counts 0..7.
- FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
  - ADDR: after 8 bits, if addr[7:1]==SLAVE_ADDR, go to ADDR_ACK and set busy. Otherwise go to IGNORE, which releases SDA and waits for START/STOP.
  - ADDR_ACK: drive 0 for one SCL period.
    - R/W=0: go to REG if this is the first address after START/STOP, else to WDATA.
    - R/W=1: pulse rd_req on the ACK-bit SCL rising edge, load rd_data into the tx shift register exactly 2 clk later, and go to RDATA.
  - REG: after 8 bits, reg_addr<=byte; go to REG_ACK (drive 0), then WDATA.
  - WDATA: after 8 bits, wr_data<=byte and wr_en pulses one clk after the 8th rising edge. Go to WDATA_ACK (drive 0); after the ACK's SCL falling edge, reg_addr<=reg_addr+1 (8-bit wrap, FF->00), then WDATA. A START during WDATA with no bits received is a repeated start and is legal.
  - RDATA: drive tx bits MSB first; a 1 bit is released, not driven. Then RDATA_ACK releases SDA and samples the master's bit.
    - Master ACK(0): reg_addr<=reg_addr+1 (wrap), pulse rd_req, reload the tx register 2 clk later, back to RDATA.
    - Master NACK(1): pulse nack_seen, go to IGNORE until STOP/START.
- SDA is never driven low while SCL=1 except when holding an ACK or data bit already set up in the low phase.
- Simultaneous START/STOP and SCL edge in the same clk: START/STOP wins.
- Reset mid-transfer: SDA is released immediately (async).

Decomposition:
- Shared package i2c_pkg: state enum encoding, I2C_RW_WRITE=0 / I2C_RW_READ=1, default FILT_LEN.
- One natural sub-module: i2c_line_filter (synchronizer + glitch filter + rise/fall pulse), instantiated twice, for SCL and SDA.

Test Plan:
- Write: START, 0x90, 0x10, 0xA5, STOP → ACK on all 3 bytes; one wr_en with reg_addr=0x10, wr_data=0xA5; then reg_addr=0x11; busy falls at STOP.
- Read: START, 0x90, 0x10, repeated START, 0x91, bank returns 0x3C, master NACK, STOP → SDA carries 0x3C; one rd_req with reg_addr=0x10; nack_seen pulses once.
- Burst read with master ACK on byte 1 from reg 0xFF → rd_req for 0xFF then 0x00 (wrap); returned bytes match the bank model.
- Wrong address 0x92 → SDA never driven low; no wr_en or rd_req; busy stays 0; the next valid transaction is ACKed.
- 1-clk glitches on SCL/SDA (< FILT_LEN) during data bits → no extra bits or spurious START/STOP; byte 0x5A is received intact.
- Reset asserted mid-RDATA while driving 0 → SDA is 'z' with no clk edge needed; outputs return to reset values.
